// File: rtl/sb_pkg.sv
// Shared types for the store buffer.
//   sb_entry_t       : per-entry state (valid/executed/committed + captured store)
//   SB_DEPTH_DEFAULT : default number of entries
package sb_pkg;

  localparam int unsigned SB_DEPTH_DEFAULT = 16;
  localparam int unsigned SB_XLEN          = 32;
  localparam int unsigned SB_PLEN          = 32;

  typedef struct packed {
    logic                   valid;
    logic                   executed;
    logic                   committed;
    logic [SB_PLEN-1:0]     addr;
    logic [SB_XLEN-1:0]     data;
    logic [SB_XLEN/8-1:0]   be;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Data-memory drain port of the store buffer.
//   master : store buffer side (drives valid/addr/data/be, receives ready)
//   slave  : memory side
interface store_buffer_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PLEN = 32
) ();

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [PLEN-1:0]   mem_req_addr;
  logic [XLEN-1:0]   mem_req_data;
  logic [XLEN/8-1:0] mem_req_be;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_data, mem_req_be,
    input  mem_req_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_data, mem_req_be,
    output mem_req_ready
  );

endinterface

// File: rtl/sb_fwd_sel.sv
// Store-to-load forwarding select. Scans the window head .. ld_sb_tail_i-1 in age
// order; the youngest executed entry with a matching word address wins.
//   entries_i     : store buffer entry array
//   head_i        : oldest entry index
//   ld_*_i        : load query (valid, address, allocation-time tail snapshot)
//   fwd_hit_o     : youngest match covers all bytes and no older address is unknown
//   fwd_data_o    : forwarded word (0 when no hit)
//   fwd_stall_o   : unknown older address or partial coverage
module sb_fwd_sel import sb_pkg::*; #(
  parameter int unsigned SB_DEPTH     = SB_DEPTH_DEFAULT,
  parameter int unsigned SB_IDX_WIDTH = $clog2(SB_DEPTH),
  parameter int unsigned XLEN         = SB_XLEN,
  parameter int unsigned PLEN         = SB_PLEN
) (
  input  sb_entry_t               entries_i [SB_DEPTH],
  input  logic [SB_IDX_WIDTH-1:0] head_i,
  input  logic                    ld_valid_i,
  input  logic [PLEN-1:0]         ld_addr_i,
  input  logic [SB_IDX_WIDTH-1:0] ld_sb_tail_i,
  output logic                    fwd_hit_o,
  output logic [XLEN-1:0]         fwd_data_o,
  output logic                    fwd_stall_o
);

  logic [SB_IDX_WIDTH-1:0] win_len;
  logic [SB_IDX_WIDTH-1:0] idx;
  logic                    found;
  logic                    unknown;
  logic [XLEN-1:0]         sel_data;
  logic [XLEN/8-1:0]       sel_be;
  logic                    full_be;
  logic                    unused_bits;

  assign win_len = ld_sb_tail_i - head_i;

  always_comb begin
    found    = 1'b0;
    unknown  = 1'b0;
    sel_data = '0;
    sel_be   = '0;
    idx      = head_i;
    // Oldest to youngest, so a later match overrides an earlier one.
    for (int unsigned k = 0; k < SB_DEPTH; k++) begin
      idx = head_i + k[SB_IDX_WIDTH-1:0];
      if (k < 32'(win_len) && entries_i[idx].valid) begin
        if (!entries_i[idx].executed) begin
          unknown = 1'b1;
        end else if (entries_i[idx].addr[PLEN-1:2] == ld_addr_i[PLEN-1:2]) begin
          found    = 1'b1;
          sel_data = entries_i[idx].data;
          sel_be   = entries_i[idx].be;
        end
      end
    end
  end

  assign full_be     = &sel_be;
  assign fwd_stall_o = ld_valid_i & (unknown | (found & ~full_be));
  assign fwd_hit_o   = ld_valid_i & found & full_be & ~unknown;
  assign fwd_data_o  = fwd_hit_o ? sel_data : '0;

  // Byte offset and commit state are irrelevant to a word-granular search.
  always_comb begin
    unused_bits = ^ld_addr_i[1:0];
    for (int unsigned k = 0; k < SB_DEPTH; k++) begin
      unused_bits = unused_bits ^ entries_i[k].committed ^ (^entries_i[k].addr[1:0]);
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer: allocates IDs at dispatch, captures LSU store
// address/data, marks ROB-committed entries, drains them in order to memory
// and supplies full-word store-to-load forwarding.
//   alloc_*   : dispatch allocation (per-lane valid, ready, assigned IDs)
//   ex_*      : LSU execute write into an allocated entry
//   commit_*  : ROB commit lanes; flush_i squashes uncommitted entries
//   mem_io    : drain port (store_buffer_if master)
//   ld_*/fwd_*: forwarding query and result
//   sb_empty_o/sb_full_o : occupancy flags
module store_buffer import sb_pkg::*; #(
  parameter int unsigned SB_DEPTH     = SB_DEPTH_DEFAULT,
  parameter int unsigned SB_IDX_WIDTH = $clog2(SB_DEPTH),
  parameter int unsigned ALLOC_WIDTH  = 4,
  parameter int unsigned COMMIT_WIDTH = 4,
  parameter int unsigned XLEN         = SB_XLEN,
  parameter int unsigned PLEN         = SB_PLEN
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [ALLOC_WIDTH-1:0]                   alloc_valid_i,
  output logic                                     alloc_ready_o,
  output logic [ALLOC_WIDTH-1:0][SB_IDX_WIDTH-1:0] alloc_sb_id_o,
  input  logic                                     ex_valid_i,
  input  logic [SB_IDX_WIDTH-1:0]                  ex_sb_id_i,
  input  logic [PLEN-1:0]                          ex_addr_i,
  input  logic [XLEN-1:0]                          ex_data_i,
  input  logic [XLEN/8-1:0]                        ex_be_i,
  input  logic [COMMIT_WIDTH-1:0]                  commit_is_store_i,
  input  logic [COMMIT_WIDTH-1:0][SB_IDX_WIDTH-1:0] commit_sb_id_i,
  input  logic                                     flush_i,
  store_buffer_if.master                           mem_io,
  input  logic                                     ld_valid_i,
  input  logic [PLEN-1:0]                          ld_addr_i,
  input  logic [SB_IDX_WIDTH-1:0]                  ld_sb_tail_i,
  output logic                                     fwd_hit_o,
  output logic [XLEN-1:0]                          fwd_data_o,
  output logic                                     fwd_stall_o,
  output logic                                     sb_empty_o,
  output logic                                     sb_full_o
);

  sb_entry_t               entries_q [SB_DEPTH];
  sb_entry_t               entries_d [SB_DEPTH];
  logic [SB_IDX_WIDTH-1:0] head_q, head_d, tail_q, tail_d, cp_q, cp_d;
  logic [SB_IDX_WIDTH:0]   count_q, count_d;
  logic [SB_IDX_WIDTH:0]   n_alloc;
  logic                    drain;
  sb_entry_t               head_ent;

  assign alloc_ready_o = (32'(SB_DEPTH) - 32'(count_q)) >= 32'(ALLOC_WIDTH);
  assign sb_empty_o    = (count_q == '0);
  assign sb_full_o     = (32'(count_q) == 32'(SB_DEPTH));

  // Lane i gets tail plus the number of requesting lanes below it.
  always_comb begin
    n_alloc = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      alloc_sb_id_o[i] = tail_q + n_alloc[SB_IDX_WIDTH-1:0];
      if (alloc_valid_i[i]) n_alloc = n_alloc + 1'b1;
    end
  end

  assign head_ent             = entries_q[head_q];
  assign mem_io.mem_req_valid = head_ent.valid & head_ent.committed;
  assign mem_io.mem_req_addr  = mem_io.mem_req_valid ? head_ent.addr : '0;
  assign mem_io.mem_req_data  = mem_io.mem_req_valid ? head_ent.data : '0;
  assign mem_io.mem_req_be    = mem_io.mem_req_valid ? head_ent.be   : '0;
  assign drain                = mem_io.mem_req_valid & mem_io.mem_req_ready;

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    cp_d      = cp_q;
    count_d   = count_q - (SB_IDX_WIDTH+1)'(drain);

    if (drain) begin
      entries_d[head_q].valid     = 1'b0;
      entries_d[head_q].executed  = 1'b0;
      entries_d[head_q].committed = 1'b0;
      head_d = head_q + 1'b1;
    end

    if (ex_valid_i && entries_q[ex_sb_id_i].valid) begin
      entries_d[ex_sb_id_i].addr     = ex_addr_i;
      entries_d[ex_sb_id_i].data     = ex_data_i;
      entries_d[ex_sb_id_i].be       = ex_be_i;
      entries_d[ex_sb_id_i].executed = 1'b1;
    end

    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (commit_is_store_i[i]) begin
        entries_d[commit_sb_id_i[i]].committed = 1'b1;
        cp_d = cp_d + 1'b1;
      end
    end

    if (alloc_ready_o && !flush_i) begin
      for (int i = 0; i < ALLOC_WIDTH; i++) begin
        if (alloc_valid_i[i]) begin
          entries_d[alloc_sb_id_o[i]].valid     = 1'b1;
          entries_d[alloc_sb_id_o[i]].executed  = 1'b0;
          entries_d[alloc_sb_id_o[i]].committed = 1'b0;
        end
      end
      tail_d  = tail_q + n_alloc[SB_IDX_WIDTH-1:0];
      count_d = count_q + n_alloc - (SB_IDX_WIDTH+1)'(drain);
    end

    if (flush_i) begin
      for (int k = 0; k < SB_DEPTH; k++) begin
        if (!entries_d[k].committed) begin
          entries_d[k].valid    = 1'b0;
          entries_d[k].executed = 1'b0;
        end
      end
      tail_d = cp_d;
      // Equal pointers mean either nothing or everything survived.
      if (cp_d == head_d) begin
        count_d = (entries_d[head_d].valid && entries_d[head_d].committed) ?
                  (SB_IDX_WIDTH+1)'(SB_DEPTH) : '0;
      end else begin
        count_d = {1'b0, cp_d - head_d};
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      cp_q    <= '0;
      count_q <= '0;
      for (int k = 0; k < SB_DEPTH; k++) entries_q[k] <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      cp_q      <= cp_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

  sb_fwd_sel #(
    .SB_DEPTH     (SB_DEPTH),
    .SB_IDX_WIDTH (SB_IDX_WIDTH),
    .XLEN         (XLEN),
    .PLEN         (PLEN)
  ) u_fwd_sel (
    .entries_i    (entries_q),
    .head_i       (head_q),
    .ld_valid_i   (ld_valid_i),
    .ld_addr_i    (ld_addr_i),
    .ld_sb_tail_i (ld_sb_tail_i),
    .fwd_hit_o    (fwd_hit_o),
    .fwd_data_o   (fwd_data_o),
    .fwd_stall_o  (fwd_stall_o)
  );

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  localparam int D = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       alloc_valid;
  logic             alloc_ready;
  logic [3:0][3:0]  alloc_id;
  logic             ex_valid;
  logic [3:0]       ex_id;
  logic [31:0]      ex_addr, ex_data;
  logic [3:0]       ex_be;
  logic [3:0]       commit_is_store;
  logic [3:0][3:0]  commit_id;
  logic             flush;
  logic             ld_valid;
  logic [31:0]      ld_addr;
  logic [3:0]       ld_tail;
  logic             fwd_hit, fwd_stall, sb_empty, sb_full;
  logic [31:0]      fwd_data;

  store_buffer_if #(.XLEN(32), .PLEN(32)) mem_if ();

  store_buffer dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .alloc_valid_i     (alloc_valid),
    .alloc_ready_o     (alloc_ready),
    .alloc_sb_id_o     (alloc_id),
    .ex_valid_i        (ex_valid),
    .ex_sb_id_i        (ex_id),
    .ex_addr_i         (ex_addr),
    .ex_data_i         (ex_data),
    .ex_be_i           (ex_be),
    .commit_is_store_i (commit_is_store),
    .commit_sb_id_i    (commit_id),
    .flush_i           (flush),
    .mem_io            (mem_if.master),
    .ld_valid_i        (ld_valid),
    .ld_addr_i         (ld_addr),
    .ld_sb_tail_i      (ld_tail),
    .fwd_hit_o         (fwd_hit),
    .fwd_data_o        (fwd_data),
    .fwd_stall_o       (fwd_stall),
    .sb_empty_o        (sb_empty),
    .sb_full_o         (sb_full)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Reference model: queue of live stores, oldest first.
  typedef struct {
    int          id;
    bit          exe;
    bit          com;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  ent_t q[$];
  int   m_head, m_tail, m_commit;
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_head = 0; m_tail = 0; m_commit = 0;
  endtask

  function automatic bit m_mvalid();
    return (q.size() > 0) && q[0].com;
  endfunction

  task automatic model_check();
    int pfx, len, found;
    bit unk, e_hit, e_stall;
    logic [31:0] e_data;
    check("alloc_ready", 64'(alloc_ready), 64'((D - q.size()) >= 4));
    check("sb_empty", 64'(sb_empty), 64'(q.size() == 0));
    check("sb_full", 64'(sb_full), 64'(q.size() == D));
    pfx = 0;
    for (int i = 0; i < 4; i++) begin
      if (alloc_valid[i]) begin
        check("alloc_id", 64'(alloc_id[i]), 64'((m_tail + pfx) % D));
        pfx++;
      end
    end
    check("mem_valid", 64'(mem_if.mem_req_valid), 64'(m_mvalid()));
    if (m_mvalid()) begin
      check("mem_addr", 64'(mem_if.mem_req_addr), 64'(q[0].addr));
      check("mem_data", 64'(mem_if.mem_req_data), 64'(q[0].data));
      check("mem_be", 64'(mem_if.mem_req_be), 64'(q[0].be));
    end
    e_hit = 0; e_stall = 0; e_data = '0;
    if (ld_valid) begin
      len = (int'(ld_tail) - m_head + D) % D;
      found = -1; unk = 0;
      for (int j = 0; j < len && j < q.size(); j++) begin
        if (!q[j].exe) unk = 1;
        else if (q[j].addr[31:2] == ld_addr[31:2]) found = j;
      end
      if (unk) e_stall = 1;
      else if (found >= 0) begin
        if (q[found].be == 4'hF) begin e_hit = 1; e_data = q[found].data; end
        else e_stall = 1;
      end
    end
    check("fwd_hit", 64'(fwd_hit), 64'(e_hit));
    check("fwd_stall", 64'(fwd_stall), 64'(e_stall));
    check("fwd_data", 64'(fwd_data), 64'(e_data));
  endtask

  task automatic model_update();
    bit ready, drn;
    ent_t e, nq[$];
    ready = (D - q.size()) >= 4;
    drn = m_mvalid() && mem_if.mem_req_ready;
    if (ex_valid) begin
      foreach (q[j]) if (q[j].id == int'(ex_id)) begin
        q[j].exe = 1; q[j].addr = ex_addr; q[j].data = ex_data; q[j].be = ex_be;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (commit_is_store[i]) begin
        foreach (q[j]) if (q[j].id == int'(commit_id[i])) q[j].com = 1;
        m_commit = (m_commit + 1) % D;
      end
    end
    if (drn) begin
      void'(q.pop_front());
      m_head = (m_head + 1) % D;
    end
    if (ready && !flush) begin
      for (int i = 0; i < 4; i++) begin
        if (alloc_valid[i]) begin
          e = '{id: m_tail, exe: 0, com: 0, addr: '0, data: '0, be: '0};
          q.push_back(e);
          m_tail = (m_tail + 1) % D;
        end
      end
    end
    if (flush) begin
      foreach (q[j]) if (q[j].com) nq.push_back(q[j]);
      q = nq;
      m_tail = m_commit;
    end
  endtask

  // Inputs are set at the falling edge; check, then take the rising edge.
  task automatic cycle();
    #1;
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_idle();
    alloc_valid = '0; ex_valid = 0; ex_id = '0; ex_addr = '0; ex_data = '0;
    ex_be = '0; commit_is_store = '0; commit_id = '0; flush = 0;
    ld_valid = 0; ld_addr = '0; ld_tail = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    set_idle();
    mem_if.mem_req_ready = 0;
    #1;
    model_reset();
    model_check();
    check("rst_mem_addr", 64'(mem_if.mem_req_addr), 64'(0));
    @(negedge clk);
    rst = 0;
  endtask

  task automatic do_exec(int id, logic [31:0] a, logic [31:0] d, logic [3:0] be);
    ex_valid = 1; ex_id = 4'(id); ex_addr = a; ex_data = d; ex_be = be;
    cycle();
    ex_valid = 0;
  endtask

  task automatic do_alloc(logic [3:0] lanes);
    alloc_valid = lanes;
    cycle();
    alloc_valid = '0;
  endtask

  initial begin
    int picks[$];
    int j;
    set_idle();
    mem_if.mem_req_ready = 0;
    @(negedge clk);
    do_reset();

    // Lanes 0,1,3 get IDs 0,1,2.
    alloc_valid = 4'b1011;
    #1;
    check("id_lane0", 64'(alloc_id[0]), 64'(0));
    check("id_lane1", 64'(alloc_id[1]), 64'(1));
    check("id_lane3", 64'(alloc_id[3]), 64'(2));
    cycle();
    alloc_valid = '0;
    #1;
    check("tail_after_alloc", 64'(alloc_id[0]), 64'(3));
    do_exec(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    commit_is_store = 4'b0001; commit_id[0] = 4'd0; mem_if.mem_req_ready = 1;
    cycle();
    commit_is_store = '0;
    #1;
    check("drain_valid", 64'(mem_if.mem_req_valid), 64'(1));
    check("drain_addr", 64'(mem_if.mem_req_addr), 64'h8000_0010);
    check("drain_data", 64'(mem_if.mem_req_data), 64'hDEAD_BEEF);
    cycle();
    #1;
    check("after_drain_valid", 64'(mem_if.mem_req_valid), 64'(0));

    // Flush keeps the committed ID0 and drops the same-cycle allocation.
    do_reset();
    do_alloc(4'b0111);
    do_exec(0, 32'h0000_0040, 32'hCAFE_0000, 4'hF);
    commit_is_store = 4'b0001; commit_id[0] = 4'd0; flush = 1; alloc_valid = 4'b1111;
    cycle();
    set_idle();
    #1;
    check("flush_tail", 64'(alloc_id[0]), 64'(1));
    check("flush_keep_valid", 64'(mem_if.mem_req_valid), 64'(1));
    check("flush_keep_addr", 64'(mem_if.mem_req_addr), 64'h40);
    mem_if.mem_req_ready = 1;
    cycle();
    #1;
    check("flush_drained_empty", 64'(sb_empty), 64'(1));

    // Fill, hold the head request, drain everything, wrap IDs.
    do_reset();
    for (int k = 0; k < 4; k++) do_alloc(4'b1111);
    #1;
    check("full_flag", 64'(sb_full), 64'(1));
    check("full_ready", 64'(alloc_ready), 64'(0));
    do_alloc(4'b1111);
    for (int k = 0; k < D; k++) do_exec(k, 32'h1000 + 32'(4 * k), 32'hA000_0000 | 32'(k), 4'hF);
    for (int k = 0; k < 4; k++) begin
      commit_is_store = 4'b1111;
      for (int i = 0; i < 4; i++) commit_id[i] = 4'(4 * k + i);
      cycle();
    end
    commit_is_store = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("hold_addr", 64'(mem_if.mem_req_addr), 64'h1000);
      cycle();
    end
    mem_if.mem_req_ready = 1;
    alloc_valid = 4'b0001;  // full with a drain: still refused
    cycle();
    alloc_valid = '0;
    for (int k = 1; k < D; k++) cycle();
    #1;
    check("drained_all_empty", 64'(sb_empty), 64'(1));
    alloc_valid = 4'b0001;
    #1;
    check("wrap_id", 64'(alloc_id[0]), 64'(0));
    cycle();
    alloc_valid = '0;

    // Forwarding.
    do_reset();
    do_alloc(4'b0011);
    do_exec(0, 32'h100, 32'h1111_1111, 4'hF);
    do_exec(1, 32'h100, 32'h2222_2222, 4'hF);
    ld_valid = 1; ld_addr = 32'h100; ld_tail = 4'd2;
    #1;
    check("fwd_young_hit", 64'(fwd_hit), 64'(1));
    check("fwd_young_data", 64'(fwd_data), 64'h2222_2222);
    cycle();
    ld_tail = 4'd1;
    #1;
    check("fwd_old_data", 64'(fwd_data), 64'h1111_1111);
    cycle();
    ld_valid = 0;
    do_exec(1, 32'h100, 32'h2222_2222, 4'h3);
    ld_valid = 1; ld_tail = 4'd2;
    #1;
    check("fwd_partial_stall", 64'(fwd_stall), 64'(1));
    check("fwd_partial_hit", 64'(fwd_hit), 64'(0));
    cycle();
    set_idle();

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      set_idle();
      if ($urandom_range(0, 2) == 0) alloc_valid = 4'($urandom_range(0, 15));
      picks.delete();
      foreach (q[k]) if (!q[k].exe) picks.push_back(k);
      if (picks.size() > 0 && $urandom_range(0, 1) == 1) begin
        j = picks[$urandom_range(0, picks.size() - 1)];
        ex_valid = 1; ex_id = 4'(q[j].id);
        ex_addr = 32'h100 + 32'(4 * $urandom_range(0, 2)) + 32'($urandom_range(0, 3));
        ex_data = $urandom();
        case ($urandom_range(0, 3))
          0: ex_be = 4'h3;
          1: ex_be = 4'hC;
          default: ex_be = 4'hF;
        endcase
      end
      foreach (q[k]) begin
        if (q[k].id == m_commit && q[k].exe && !q[k].com && $urandom_range(0, 1) == 1) begin
          commit_is_store = 4'($urandom_range(0, 3) == 0 ? 4'b0100 : 4'b0001);
          for (int i = 0; i < 4; i++) commit_id[i] = 4'(m_commit);
        end
      end
      flush = ($urandom_range(0, 24) == 0);
      mem_if.mem_req_ready = 1'($urandom_range(0, 1));
      ld_valid = 1'($urandom_range(0, 1));
      ld_addr = 32'h100 + 32'(4 * $urandom_range(0, 3));
      ld_tail = 4'((m_head + int'($urandom_range(0, q.size()))) % D);
      cycle();
    end
    set_idle();

    // Asynchronous reset in the middle of a stalled drain.
    do_reset();
    do_alloc(4'b0001);
    do_exec(0, 32'h200, 32'h5555_AAAA, 4'hF);
    commit_is_store = 4'b0001; commit_id[0] = 4'd0;
    cycle();
    commit_is_store = '0;
    #1;
    check("pre_rst_valid", 64'(mem_if.mem_req_valid), 64'(1));
    #2;
    rst = 1;
    #1;
    model_reset();
    check("async_rst_valid", 64'(mem_if.mem_req_valid), 64'(0));
    check("async_rst_addr", 64'(mem_if.mem_req_addr), 64'(0));
    check("async_rst_data", 64'(mem_if.mem_req_data), 64'(0));
    check("async_rst_empty", 64'(sb_empty), 64'(1));
    check("async_rst_ready", 64'(alloc_ready), 64'(1));
    @(negedge clk);
    mem_if.mem_req_ready = 1;
    cycle();
    rst = 0;
    cycle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
